mem_access_ctrl: RTL and testbench

Sequencer for the MEM stage of the 5-stage MIPS pipeline. It takes the MEM-stage control bits (MemRead, MemWrite, Branch, bne) and the EX/MEM address and store data, runs a request/acknowledge transaction against a variable-latency data memory, and stalls the pipeline until the access completes. It also resolves beq/bne into a PC-select/flush pulse, times out hung accesses, and rejects misaligned word accesses.

---
 rtl/mem_ctrl_pkg.sv | 24 ++
 rtl/mem_timeout_ctr.sv | 26 ++
 rtl/mem_access_ctrl.sv | 108 ++++++++++
 tb/tb_mem_access_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage access sequencer: FSM encoding and the
// load/store/branch opcodes also used by the decode-side control.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;

   function automatic logic is_mem_op(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

   function automatic logic is_branch_op(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating 8-bit cycle counter for the data-memory request; flags when the
// number of counted cycles equals TIMEOUT.
module mem_timeout_ctr #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT);

   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (en && (count != 8'hFF))
         count <= count + 8'd1;
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: request/ack handshake with a variable-latency data
// memory, pipeline stall, beq/bne resolution, misalign rejection and timeout.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no access pending; accepts aligned loads/stores, resolves branches
// REQ     | dmem_req held, waiting for dmem_ack or timeout; pipeline stalled
// DONE    | one-cycle completion; rdata/timeout_err valid, pipeline advances
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              branch,
   input  logic              bne,
   input  logic              alu_zero,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [DATA_W-1:0] rdata,
   output logic              stall,
   output logic              pc_src,
   output logic              misalign_err,
   output logic              timeout_err
);

   state_t            state;
   logic [DATA_W-1:0] rdata_q;
   logic              access;
   logic              aligned;
   logic              accept;
   logic              ctr_en;
   logic              expired;

   assign access  = mem_read | mem_write;
   assign aligned = (addr[1:0] == 2'b00);
   assign accept  = (state == ST_IDLE) && access && aligned;

   assign stall        = !rst && (accept || (state == ST_REQ));
   assign misalign_err = !rst && (state == ST_IDLE) && access && !aligned;
   assign pc_src       = !rst && (state == ST_IDLE) && !access && branch && (alu_zero ^ bne);
   assign rdata        = misalign_err ? '0 : rdata_q;

   // Counting starts in the accept cycle so expiry lands on REQ cycle TIMEOUT.
   assign ctr_en = accept || ((state == ST_REQ) && !dmem_ack);

   mem_timeout_ctr #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout_ctr (
      .clk    (clk),
      .rst    (rst),
      .clr    (!ctr_en),
      .en     (ctr_en),
      .expired(expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         dmem_addr   <= '0;
         dmem_wdata  <= '0;
         rdata_q     <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state      <= ST_REQ;
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_write;
                  dmem_addr  <= addr;
                  dmem_wdata <= wdata;
                  rdata_q    <= '0;
               end
            end
            ST_REQ: begin
               if (dmem_ack) begin
                  state    <= ST_DONE;
                  dmem_req <= 1'b0;
                  rdata_q  <= dmem_we ? '0 : dmem_rdata;
               end else if (expired) begin
                  state       <= ST_DONE;
                  dmem_req    <= 1'b0;
                  rdata_q     <= '0;
                  timeout_err <= 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed test-plan cases plus
// random accesses checked against a per-transaction timing model.
module tb_mem_access_ctrl;

   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write, branch, bne, alu_zero;
   logic [31:0] addr, wdata;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata, rdata;
   logic        stall, pc_src, misalign_err, timeout_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write),
      .branch(branch), .bne(bne), .alu_zero(alu_zero),
      .addr(addr), .wdata(wdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .rdata(rdata), .stall(stall), .pc_src(pc_src),
      .misalign_err(misalign_err), .timeout_err(timeout_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle: inputs are driven 1 time unit after the edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mem_read = 0; mem_write = 0; branch = 0; bne = 0; alu_zero = 0;
      addr = 0; wdata = 0; dmem_ack = 0; dmem_rdata = 0;
   endtask

   // One aligned access. ack_at is the cycle index (t0 = access seen) at
   // which memory acknowledges; values outside 1..TMO mean no ack.
   task automatic run_access(input bit wr, input bit rd, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rdv,
                             input int ack_at);
      bit          acked;
      int          last_req;
      logic [31:0] exp_rdata;
      acked     = (ack_at >= 1) && (ack_at <= TMO);
      last_req  = acked ? ack_at : TMO;
      exp_rdata = (acked && !wr) ? rdv : 32'h0;
      for (int i = 0; i <= last_req + 1; i++) begin
         next_cycle();
         if (i == 0) begin
            mem_read = rd; mem_write = wr; addr = a; wdata = wd;
         end
         if (i == last_req + 1) begin
            mem_read = 0; mem_write = 0;
         end
         dmem_ack   = acked && (i == ack_at);
         dmem_rdata = (i == ack_at) ? rdv : $urandom;
         @(negedge clk);
         chk("stall", stall, i <= last_req);
         chk("dmem_req", dmem_req, (i >= 1) && (i <= last_req));
         chk("pc_src_during_access", pc_src, 0);
         if ((i >= 1) && (i <= last_req)) begin
            chk("dmem_we", dmem_we, wr);
            chk("dmem_addr", dmem_addr, a);
            if (wr) chk("dmem_wdata", dmem_wdata, wd);
         end
         if (i == last_req + 1) begin
            chk("rdata_done", rdata, exp_rdata);
            chk("timeout_err_done", timeout_err, !acked);
         end else begin
            chk("timeout_err_quiet", timeout_err, 0);
         end
      end
      // Late/spurious ack in IDLE must be ignored.
      next_cycle();
      dmem_ack = 1; dmem_rdata = $urandom;
      @(negedge clk);
      chk("idle_req_after_late_ack", dmem_req, 0);
      chk("idle_stall", stall, 0);
      next_cycle();
      dmem_ack = 0;
      @(negedge clk);
      chk("idle_req_stays_low", dmem_req, 0);
      chk("rdata_hold_after_late_ack", rdata, exp_rdata);
      chk("timeout_err_one_cycle", timeout_err, 0);
   endtask

   initial begin
      clear_inputs();
      rst = 1;

      // Reset: registered outputs 0, combinational outputs forced low.
      next_cycle();
      mem_read = 1; addr = 32'h10; branch = 1; alu_zero = 1;
      @(negedge clk);
      chk("rst_stall", stall, 0);
      chk("rst_pc_src", pc_src, 0);
      chk("rst_dmem_req", dmem_req, 0);
      chk("rst_dmem_we", dmem_we, 0);
      chk("rst_dmem_addr", dmem_addr, 0);
      chk("rst_dmem_wdata", dmem_wdata, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_timeout_err", timeout_err, 0);
      next_cycle();
      addr = 32'h13;
      @(negedge clk);
      chk("rst_misalign", misalign_err, 0);
      next_cycle();
      clear_inputs();
      rst = 0;

      // Load, ack at t3.
      run_access(0, 1, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3);
      // Store, minimum latency.
      run_access(1, 0, 32'h0000_0020, 32'h1234_5678, 32'hCAFE_F00D, 1);
      // Timeout: read with no ack.
      run_access(0, 1, 32'h0000_0100, 32'h0, 32'h5555_AAAA, 0);
      // Read and write both set: write wins, rdata stays 0.
      run_access(1, 1, 32'h0000_0044, 32'hA5A5_0001, 32'hFFFF_FFFF, 2);
      // Ack on the very cycle the counter would expire still completes.
      run_access(0, 1, 32'h0000_0080, 32'h0, 32'h0BAD_CAFE, TMO);

      // Load to leave a non-zero rdata, then misalign forces it to 0.
      run_access(0, 1, 32'h0000_0008, 32'h0, 32'h7777_1111, 2);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         mem_read = 1; addr = 32'h0000_0013;
         @(negedge clk);
         chk("misalign_err", misalign_err, 1);
         chk("misalign_stall", stall, 0);
         chk("misalign_req", dmem_req, 0);
         chk("misalign_rdata", rdata, 0);
      end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      chk("misalign_clears", misalign_err, 0);
      chk("misalign_no_req", dmem_req, 0);

      // Branch resolution: taken when (beq and zero) or (bne and not zero).
      for (int i = 0; i < 8; i++) begin
         logic b, n, z;
         b = i[2]; n = i[1]; z = i[0];
         next_cycle();
         branch = b; bne = n; alu_zero = z;
         @(negedge clk);
         chk("pc_src", pc_src, b && (n ? !z : z));
      end
      next_cycle();
      branch = 1; bne = 1; alu_zero = 0;
      @(negedge clk);
      chk("pc_src_bne_taken", pc_src, 1);

      // Branch with a memory access set: the access proceeds, no pc_src.
      run_access(0, 1, 32'h0000_0030, 32'h0, 32'h1357_9BDF, 2);
      next_cycle();
      clear_inputs();

      // Reset mid-access.
      next_cycle();
      mem_read = 1; addr = 32'h0000_0040;
      @(negedge clk);
      chk("rstmid_t0_stall", stall, 1);
      next_cycle();
      @(negedge clk);
      chk("rstmid_t1_req", dmem_req, 1);
      next_cycle();
      rst = 1;
      @(negedge clk);
      chk("rstmid_t2_stall", stall, 0);
      next_cycle();
      rst = 0; mem_read = 0; addr = 0;
      @(negedge clk);
      chk("rstmid_t3_req", dmem_req, 0);
      chk("rstmid_t3_stall", stall, 0);
      next_cycle();
      dmem_ack = 1; dmem_rdata = 32'hFEED_FACE;
      @(negedge clk);
      chk("rstmid_t4_req", dmem_req, 0);
      next_cycle();
      dmem_ack = 0; dmem_rdata = 0;
      @(negedge clk);
      chk("rstmid_t5_rdata", rdata, 0);
      chk("rstmid_t5_req", dmem_req, 0);
      run_access(0, 1, 32'h0000_0040, 32'h0, 32'h2468_ACE0, 2);

      // Random aligned accesses with random ack latency (or none).
      for (int n = 0; n < 20; n++) begin
         bit          wr, rd;
         logic [31:0] a, wd, rv;
         int          k;
         wr = 1'($urandom_range(0, 1));
         rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         a  = $urandom;
         a[1:0] = 2'b00;
         wd = $urandom;
         rv = $urandom;
         k  = $urandom_range(0, TMO + 3);
         run_access(wr, rd, a, wd, rv, k);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
